hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, FP long-op stall, external halt.
// Optional FP long-op stall is built only when HAZARD_FP_STALL_EN is defined.
module hazard_ctrl #(
    parameter int FP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        fp_start,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FP_BUSY = 2'b01,
        HALT    = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic        load_use;
    logic        fp_go;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

`ifdef HAZARD_FP_STALL_EN
    localparam logic [7:0] FP_LOAD = 8'(FP_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Entry is lower priority than branch, halt and load-use; those are gated in the RUN arm.
    assign fp_go = fp_start && !load_use;
`else
    logic fp_unused;

    assign fp_go     = 1'b0;
    assign fp_unused = fp_start & (FP_CYCLES > 1);
`endif

    // Control outputs: reset forces a bubble+flush; non-RUN states hold the front end.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == RUN) begin
            if (branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
            end else if (jump_id) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
            end
        end else begin
            idex_bubble = 1'b1;
            ifid_flush  = branch_taken;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (!branch_taken) begin
                    if (halt_req)   state_d = HALT;
                    else if (fp_go) state_d = FP_BUSY;
                end
            end
`ifdef HAZARD_FP_STALL_EN
            FP_BUSY: begin
                if (cnt_q == 8'd0) state_d = RUN;
            end
`endif
            HALT: begin
                if (!halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef HAZARD_FP_STALL_EN
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RUN && state_d == FP_BUSY)
            cnt_d = FP_LOAD;
        else if (state_q == FP_BUSY && cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end
`endif

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stall_q <= 16'd0;
`ifdef HAZARD_FP_STALL_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
`ifdef HAZARD_FP_STALL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected outputs go through a scoreboard queue per cycle.
module tb_hazard_ctrl;
    localparam int FP_CYCLES = 8;
    localparam logic [1:0] S_RUN = 2'b00, S_FP = 2'b01, S_HALT = 2'b10;
    // control nibble = {pc_write, ifid_write, ifid_flush, idex_bubble}
    localparam logic [3:0] NORM = 4'b1100, STALL = 4'b0001, BRANCH = 4'b1111,
                           JUMP = 4'b1110, HOLD_BR = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, branch_taken, jump_id, fp_start, halt_req;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    hazard_ctrl #(.FP_CYCLES(FP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump_id(jump_id),
        .fp_start(fp_start), .halt_req(halt_req), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .state(state),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [1:0]  st;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] s0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic jmp, input logic fps, input logic hlt);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
        branch_taken = br; jump_id = jmp; fp_start = fps; halt_req = hlt;
    endtask

    // Called at posedge+1 with inputs applied; compares at negedge, returns at next posedge+1.
    task automatic cyc(input string tag, input logic [3:0] ctl, input logic [1:0] st);
        exp_t e;
        e.ctl = ctl; e.st = st; e.stall = exp_stall;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_bubble}), 32'(e.ctl));
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
        @(posedge clk);
        #1;
        if (!e.ctl[3] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_bubble}), 32'(HOLD_BR));
        chk({tag, ".state"}, 32'(state), 32'(S_RUN));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stall = 16'd0;

        cyc("idle", NORM, S_RUN);
        drive(3, 0, 0, 1, 3, 0, 0, 0, 0);  cyc("lu_rs", STALL, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("lu_done", NORM, S_RUN);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);  cyc("lu_r0", NORM, S_RUN);
        drive(1, 7, 1, 1, 7, 0, 0, 0, 0);  cyc("lu_rt", STALL, S_RUN);
        drive(1, 7, 0, 1, 7, 0, 0, 0, 0);  cyc("lu_rt_unused", NORM, S_RUN);
        drive(3, 0, 0, 0, 3, 0, 0, 0, 0);  cyc("no_memread", NORM, S_RUN);
        drive(3, 0, 0, 1, 3, 1, 0, 0, 0);  cyc("br_over_lu", BRANCH, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc("jump", JUMP, S_RUN);
        drive(4, 0, 0, 1, 4, 0, 1, 0, 0);  cyc("lu_over_jump", STALL, S_RUN);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);  cyc("br_over_jump", BRANCH, S_RUN);

        // halt held for 5 cycles from RUN
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("halt_req", NORM, S_RUN);
        for (int i = 0; i < 4; i++) cyc("halt_hold", STALL, S_HALT);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("halt_last", STALL, S_HALT);
        cyc("halt_exit", NORM, S_RUN);

        // branch blocks halt entry; branch during HALT flushes but holds PC
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);  cyc("br_blocks_halt", BRANCH, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("halt_enter2", NORM, S_RUN);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);  cyc("br_in_halt", HOLD_BR, S_HALT);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("halt_leave2", STALL, S_HALT);
        cyc("run_again", NORM, S_RUN);

        // halt beats load-use and fp_start
        drive(5, 0, 0, 1, 5, 0, 0, 1, 1);  cyc("halt_over_lu", STALL, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("halt_from_lu", STALL, S_HALT);
        cyc("run_after_lu", NORM, S_RUN);

`ifdef HAZARD_FP_STALL_EN
        // FP long op: 8 busy cycles, halt raised mid-op is deferred
        s0 = exp_stall;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("fp_issue", NORM, S_RUN);
        for (int i = 0; i < FP_CYCLES; i++) begin
            drive(2, 0, 0, 1, 2, (i == 1), 0, 0, (i >= 3));
            cyc("fp_busy", (i == 1) ? HOLD_BR : STALL, S_FP);
        end
        chk("fp_stall_delta", 32'(stall_cycles), 32'(s0 + 16'd8));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("fp_done_halt", NORM, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("deferred_halt", STALL, S_HALT);
        cyc("fp_run", NORM, S_RUN);

        // fp_start suppressed by load-use and by branch
        drive(6, 0, 0, 1, 6, 0, 0, 1, 0);  cyc("fp_vs_lu", STALL, S_RUN);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);  cyc("fp_vs_br", BRANCH, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("fp_not_entered", NORM, S_RUN);

        // reset in the middle of FP_BUSY
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("fp_issue2", NORM, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("fp_busy2", STALL, S_FP);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid_fp");
`else
        // FP stall not built: fp_start has no effect
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("fp_ignored", NORM, S_RUN);
        cyc("fp_ignored2", NORM, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("fp_ignored3", NORM, S_RUN);

        // reset in the middle of HALT
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("halt_enter3", NORM, S_RUN);
        cyc("halt_hold3", STALL, S_HALT);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid_halt");
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stall = 16'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("post_reset", NORM, S_RUN);
        drive(9, 0, 0, 1, 9, 0, 0, 0, 0);  cyc("post_reset_lu", STALL, S_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("post_reset_idle", NORM, S_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
